frame_depack_p: RTL and testbench

Parametrised command-frame depacketiser, the successor to the fixed 46-byte depacker. It receives a byte stream (the SPI-slave/FIFO output) and hunts for frames with a two-byte header and a trailing 8-bit additive checksum. It resynchronises by sliding one byte at a time and presents each accepted frame as a flat bus, held until the consumer acknowledges it. It sits between the rx FIFO and the per-field command registers of the top level.

---
 rtl/frame_depack_p_if.sv | 25 ++
 rtl/frame_depack_p.sv | 200 ++++++++++++++++++++
 tb/tb_frame_depack_p.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_depack_p_if.sv
// frame_depack_p_if: byte-stream input and flat-frame output of the command-frame depacketiser.
// master = stream producer / frame consumer side, slave = the depacketiser.
interface frame_depack_p_if #(
  parameter int FRAME_LEN = 46
);
  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   in_ready;
  logic [8*FRAME_LEN-1:0] frame_data;
  logic                   frame_valid;
  logic                   frame_ack;
  logic                   crc_err;
  logic                   to_err;
  logic [15:0]            err_cnt;

  modport master (
    output in_valid, in_data, frame_ack,
    input  in_ready, frame_data, frame_valid, crc_err, to_err, err_cnt
  );

  modport slave (
    input  in_valid, in_data, frame_ack,
    output in_ready, frame_data, frame_valid, crc_err, to_err, err_cnt
  );
endinterface

// File: rtl/frame_depack_p.sv
// frame_depack_p: hunts a byte stream for HDR0/HDR1-headed frames with a trailing
// 8-bit additive checksum, sliding one byte per mismatch, and holds each verified
// frame on a flat bus until frame_ack. Byte 0 sits in the MSBs of frame_data.
// Optional feature: define DEPACK_TIMEOUT_EN to discard a partial frame after
// TIMEOUT_CYC idle clocks (pulses to_err); otherwise to_err is tied low.
module frame_depack_p #(
  parameter int         FRAME_LEN   = 46,
  parameter logic [7:0] HDR0        = 8'hEB,
  parameter logic [7:0] HDR1        = 8'h90,
  parameter int         TIMEOUT_CYC = 65535
) (
  input logic             clk,
  input logic             rst,
  frame_depack_p_if.slave bus
);

  localparam int FW = $clog2(FRAME_LEN + 1);
  localparam int BW = 8 * FRAME_LEN;

  typedef enum logic [2:0] {S_FILL, S_SUM, S_JUDGE, S_SLIDE, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [FW-1:0]   idx_q, idx_d;
  logic [7:0]      acc_q, acc_d;
  logic [BW-1:0]   fdata_q, fdata_d;
  logic            fvalid_q, fvalid_d;
  logic            crc_q, crc_d;
  logic [15:0]     err_q, err_d;
  logic            in_ready_q, in_ready_d;
  logic            accept_s;
  logic [7:0]      sel_byte_s;
`ifdef DEPACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            to_q, to_d;
`endif

  assign accept_s = bus.in_valid && in_ready_q;

  // Select buf[idx] for the checksum accumulator.
  always_comb begin
    sel_byte_s = 8'h00;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (idx_q == FW'(i)) begin
        sel_byte_s = buf_q[8*(FRAME_LEN-1-i) +: 8];
      end else begin
        sel_byte_s = sel_byte_s;
      end
    end
  end

  // Next-state and datapath decode for FILL/SUM/JUDGE/SLIDE/HOLD.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    fill_d   = fill_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    fdata_d  = fdata_q;
    fvalid_d = fvalid_q;
    crc_d    = 1'b0;
    err_d    = err_q;
`ifdef DEPACK_TIMEOUT_EN
    tcnt_d   = TW'(0);
    to_d     = 1'b0;
`endif
    case (state_q)
      S_FILL: begin
        if (accept_s) begin
          for (int i = 0; i < FRAME_LEN; i++) begin
            if (fill_q == FW'(i)) begin
              buf_d[8*(FRAME_LEN-1-i) +: 8] = bus.in_data;
            end else begin
              buf_d[8*(FRAME_LEN-1-i) +: 8] = buf_d[8*(FRAME_LEN-1-i) +: 8];
            end
          end
          fill_d = fill_q + FW'(1);
          if (fill_q == FW'(FRAME_LEN - 1)) begin
            state_d = S_SUM;
            idx_d   = FW'(0);
            acc_d   = 8'h00;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
`ifdef DEPACK_TIMEOUT_EN
        // Idle clocks only count while a partial frame is buffered.
        if (fill_q == FW'(0) || accept_s) begin
          tcnt_d = TW'(0);
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          tcnt_d = TW'(0);
          fill_d = FW'(0);
          to_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
`endif
      end
      S_SUM: begin
        acc_d = acc_q + sel_byte_s;
        idx_d = idx_q + FW'(1);
        if (idx_q == FW'(FRAME_LEN - 2)) begin
          state_d = S_JUDGE;
        end else begin
          state_d = S_SUM;
        end
      end
      S_JUDGE: begin
        if (buf_q[BW-1 -: 8] != HDR0 || buf_q[BW-9 -: 8] != HDR1) begin
          state_d = S_SLIDE;
        end else if (acc_q != buf_q[7:0]) begin
          crc_d   = 1'b1;
          err_d   = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
          state_d = S_SLIDE;
        end else begin
          fdata_d  = buf_q;
          fvalid_d = 1'b1;
          fill_d   = FW'(0);
          state_d  = S_HOLD;
        end
      end
      S_SLIDE: begin
        // Drop byte 0; the next accepted byte completes the window again.
        buf_d   = buf_q << 8;
        fill_d  = FW'(FRAME_LEN - 1);
        state_d = S_FILL;
      end
      S_HOLD: begin
        if (bus.frame_ack) begin
          fvalid_d = 1'b0;
          state_d  = S_FILL;
        end else begin
          state_d  = S_HOLD;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
    in_ready_d = (state_d == S_FILL);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_q      <= '0;
      fill_q     <= FW'(0);
      idx_q      <= FW'(0);
      acc_q      <= 8'h00;
      fdata_q    <= '0;
      fvalid_q   <= 1'b0;
      crc_q      <= 1'b0;
      err_q      <= 16'h0000;
      in_ready_q <= 1'b0;
`ifdef DEPACK_TIMEOUT_EN
      tcnt_q     <= TW'(0);
      to_q       <= 1'b0;
`endif
    end else begin
      buf_q      <= buf_d;
      fill_q     <= fill_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      fdata_q    <= fdata_d;
      fvalid_q   <= fvalid_d;
      crc_q      <= crc_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
`ifdef DEPACK_TIMEOUT_EN
      tcnt_q     <= tcnt_d;
      to_q       <= to_d;
`endif
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.frame_data  = fdata_q;
  assign bus.frame_valid = fvalid_q;
  assign bus.crc_err     = crc_q;
  assign bus.err_cnt     = err_q;
`ifdef DEPACK_TIMEOUT_EN
  assign bus.to_err      = to_q;
`else
  assign bus.to_err      = 1'b0;
`endif

endmodule

// File: tb/tb_frame_depack_p.sv
// Directed bench for frame_depack_p with FRAME_LEN=6, HDR=EB 90, TIMEOUT_CYC=20.
module tb_frame_depack_p;

  localparam logic [47:0] GOOD = 48'hEB9001020381;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   crc_seen;
  int   to_seen;

  frame_depack_p_if #(.FRAME_LEN(6)) bus ();

  frame_depack_p #(
    .FRAME_LEN(6), .HDR0(8'hEB), .HDR1(8'h90), .TIMEOUT_CYC(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output pulses, one sample per cycle.
  always @(negedge clk) begin
    if (bus.crc_err === 1'b1) crc_seen++;
    if (bus.to_err === 1'b1) to_seen++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int n = 0; n < 200 && !done; n++) begin
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte: byte %02h not accepted, required acceptance within 200 cycles", b);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_seq(input logic [63:0] v, input int n);
    for (int k = 0; k < n; k++) send_byte(v[8*(n-1-k) +: 8]);
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (bus.frame_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_wait: frame_valid=%b, required 1 within 100 cycles", tag, bus.frame_valid);
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    bus.frame_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.frame_ack = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.frame_valid !== 1'b0 || bus.frame_data !== 48'h0 ||
        bus.err_cnt !== 16'h0 || bus.crc_err !== 1'b0 || bus.to_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals: rdy=%b fv=%b fd=%h err=%h crc=%b to=%b, required all 0",
               bus.in_ready, bus.frame_valid, bus.frame_data, bus.err_cnt, bus.crc_err, bus.to_err);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_good_frame();
    int c0;
    c0 = crc_seen;
    send_seq(64'hEB90010203, 5);
    send_byte(8'h81);
    repeat (6) @(negedge clk);
    n_checks++;
    if (bus.frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL good_early: frame_valid=%b at T+6, required 0", bus.frame_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_data !== GOOD) begin
      n_fail++;
      $display("FAIL good_T7: fv=%b fd=%h, required fv=1 fd=%h", bus.frame_valid, bus.frame_data, GOOD);
    end
    n_checks++;
    if (crc_seen !== c0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL good_crc_rdy: crc pulses=%0d rdy=%b, required 0 and 0", crc_seen - c0, bus.in_ready);
    end
    bus.frame_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.frame_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL good_ack: fv=%b rdy=%b, required fv=0 rdy=1", bus.frame_valid, bus.in_ready);
    end
  endtask

  task automatic test_misalign();
    int c0;
    c0 = crc_seen;
    send_seq(64'h55AAEB9001020381, 8);
    wait_valid("misalign");
    n_checks++;
    if (bus.frame_data !== GOOD || crc_seen !== c0 || bus.err_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL misalign_lock: fd=%h crc=%0d err=%h, required fd=%h crc=0 err=0",
               bus.frame_data, crc_seen - c0, bus.err_cnt, GOOD);
    end
    do_ack();
  endtask

  task automatic test_timeout();
    int t0;
    t0 = to_seen;
    send_seq(64'hEB9001, 3);
    bus.in_valid = 1'b0;
    repeat (25) @(negedge clk);
`ifdef DEPACK_TIMEOUT_EN
    n_checks++;
    if (to_seen !== t0 + 1 || bus.frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse: to pulses=%0d fv=%b, required 1 and 0", to_seen - t0, bus.frame_valid);
    end
    send_seq(64'hEB9001020381, 6);
    wait_valid("timeout_after");
    n_checks++;
    if (bus.frame_data !== GOOD) begin
      n_fail++;
      $display("FAIL timeout_after_data: fd=%h, required %h", bus.frame_data, GOOD);
    end
    do_ack();
`else
    n_checks++;
    if (to_seen !== t0 || bus.frame_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL no_timeout: to pulses=%0d fv=%b rdy=%b, required 0 0 1",
               to_seen - t0, bus.frame_valid, bus.in_ready);
    end
    do_reset();
`endif
  endtask

  task automatic test_bad_crc();
    int c0;
    c0 = crc_seen;
    send_seq(64'hEB90010203, 5);
    send_byte(8'h80);
    repeat (7) @(negedge clk);
    n_checks++;
    if (bus.crc_err !== 1'b1 || bus.err_cnt !== 16'd1 || bus.frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL badcrc_T7: crc=%b err=%h fv=%b, required crc=1 err=1 fv=0",
               bus.crc_err, bus.err_cnt, bus.frame_valid);
    end
    send_seq(64'h0000000000, 5);
    send_seq(64'hEB9001020381, 6);
    wait_valid("badcrc_relock");
    n_checks++;
    if (bus.frame_data !== GOOD || bus.err_cnt !== 16'd1 || crc_seen !== c0 + 1) begin
      n_fail++;
      $display("FAIL badcrc_relock: fd=%h err=%h crc=%0d, required fd=%h err=1 crc=1",
               bus.frame_data, bus.err_cnt, crc_seen - c0, GOOD);
    end
    do_ack();
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    send_seq(64'hEB9001020381, 6);
    wait_valid("bp");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.frame_valid !== 1'b1 || bus.frame_data !== GOOD) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d bad cycles, required 0", bad);
    end
    bus.in_valid  = 1'b0;
    bus.frame_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ack: rdy=%b fv=%b, required rdy=1 fv=0", bus.in_ready, bus.frame_valid);
    end
  endtask

  task automatic test_reset_hold();
    send_seq(64'hEB9001020381, 6);
    wait_valid("rsthold");
    n_checks++;
    if (bus.err_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL rsthold_pre_err: err=%h, required 1", bus.err_cnt);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.frame_valid !== 1'b0 || bus.frame_data !== 48'h0 || bus.err_cnt !== 16'h0 ||
        bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rsthold: fv=%b fd=%h err=%h rdy=%b, required all 0",
               bus.frame_valid, bus.frame_data, bus.err_cnt, bus.in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    crc_seen = 0;
    to_seen  = 0;
    test_reset();
    test_good_frame();
    test_misalign();
    test_timeout();
    test_bad_crc();
    test_backpressure();
    test_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
